// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter for the shared SPI config flash: per-transaction ownership,
// round-robin ties, CS-high guard time between owners and optional idle-owner revoke.
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       m0_req,
  output logic       m0_gnt,
  input  logic       m0_csel,
  input  logic       m0_sclk,
  input  logic       m0_mosi,
  output logic       m0_miso,
  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic       m1_csel,
  input  logic       m1_sclk,
  input  logic       m1_mosi,
  output logic       m1_miso,
  output logic       flash_csel,
  output logic       flash_sclk,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic [1:0] owner,
  output logic       timeout_err
);

  localparam int unsigned GUARD_W = 8;
  localparam int unsigned TMO_W   = 24;
  localparam bit             TMO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [TMO_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 m0_gnt_q, m0_gnt_d;
  logic                 m1_gnt_q, m1_gnt_d;
  logic [1:0]           owner_q, owner_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 own_req;
  logic                 own_csel;
  logic                 tmo_hit;
  logic [TMO_W-1:0]     idle_inc;

  // Current owner's handshake signals, and the idle-timeout condition.
  always_comb begin
    own_req  = (state_q == ST_OWN1) ? m1_req  : m0_req;
    own_csel = (state_q == ST_OWN1) ? m1_csel : m0_csel;
    tmo_hit  = TMO_EN && own_req && own_csel && (idle_cnt_q >= TMO_LAST);
    idle_inc = (idle_cnt_q < TMO_MAX) ? idle_cnt_q + TMO_W'(1) : idle_cnt_q;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    guard_cnt_d   = guard_cnt_q;
    idle_cnt_d    = '0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // last_q=1 means m1 was the previous owner, so m0 wins a tie.
        if (m0_req && (!m1_req || last_q)) begin
          state_d = ST_OWN0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if ((!own_req && own_csel) || tmo_hit) begin
          state_d     = ST_GUARD;
          last_d      = (state_q == ST_OWN1);
          guard_cnt_d = GUARD_W'(GUARD_CYCLES);
          if (tmo_hit) begin
            timeout_err_d = 1'b1;
          end
        end else if (TMO_EN && own_csel) begin
          idle_cnt_d = idle_inc;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q <= GUARD_W'(1)) begin
          state_d     = ST_IDLE;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q - GUARD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m0_gnt_d = (state_d == ST_OWN0);
    m1_gnt_d = (state_d == ST_OWN1);
    owner_d  = {m1_gnt_d, m0_gnt_d};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      guard_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      m0_gnt_q      <= 1'b0;
      m1_gnt_q      <= 1'b0;
      owner_q       <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      guard_cnt_q   <= guard_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      m0_gnt_q      <= m0_gnt_d;
      m1_gnt_q      <= m1_gnt_d;
      owner_q       <= owner_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Zero-latency pin mux; idle levels whenever nobody owns the flash.
  always_comb begin
    flash_csel = 1'b1;
    flash_sclk = 1'b0;
    flash_mosi = 1'b0;
    if (state_q == ST_OWN0) begin
      flash_csel = m0_csel;
      flash_sclk = m0_sclk;
      flash_mosi = m0_mosi;
    end else if (state_q == ST_OWN1) begin
      flash_csel = m1_csel;
      flash_sclk = m1_sclk;
      flash_mosi = m1_mosi;
    end
  end

  assign m0_miso     = m0_gnt_q & flash_miso;
  assign m1_miso     = m1_gnt_q & flash_miso;
  assign m0_gnt      = m0_gnt_q;
  assign m1_gnt      = m1_gnt_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule
